ram_port_arb: RTL and testbench

- Arbitrates the single RAM port A between two requesters.
  - m0: the core data-side mux.
  - m1: the UART software-upgrade loader.
- Replaces the static "upgrade wins" mux in front of the RAM.
- Adds:
  - a per-requester req/ready handshake;
  - read-response routing, matched to the RAM's 1-cycle read latency;
  - an anti-starvation counter;
  - a lock for back-to-back loader bursts.
- Sits between d_mux / uart_mgr and ram_sdp port A.

---
 rtl/ram_port_arb.sv | 133 +++++++++++++
 tb/tb_ram_port_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arb.sv
// Arbiter for RAM port A between the core data mux (m0) and the UART loader (m1).
// Define RAM_ARB_RR_EN for round-robin base priority; otherwise m1 has fixed priority over m0.
module ram_port_arb #(
  parameter int XLEN         = 32,
  parameter int RAM_ADDR_LEN = 14,
  parameter int MAX_WAIT     = 4
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    m0_req,
  input  logic [XLEN/8-1:0]       m0_we,
  input  logic [RAM_ADDR_LEN-1:0] m0_addr,
  input  logic [XLEN-1:0]         m0_wdata,
  output logic                    m0_ready,
  output logic                    m0_rvalid,
  output logic [XLEN-1:0]         m0_rdata,
  input  logic                    m1_req,
  input  logic [XLEN/8-1:0]       m1_we,
  input  logic [RAM_ADDR_LEN-1:0] m1_addr,
  input  logic [XLEN-1:0]         m1_wdata,
  output logic                    m1_ready,
  output logic                    m1_rvalid,
  output logic [XLEN-1:0]         m1_rdata,
  input  logic                    m1_lock,
  output logic                    ram_en,
  output logic [XLEN/8-1:0]       ram_we,
  output logic [RAM_ADDR_LEN-1:0] ram_addr,
  output logic [XLEN-1:0]         ram_wdata,
  input  logic [XLEN-1:0]         ram_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic       active_q, active_d;
  logic       owner_q, owner_d;
  logic [3:0] wait0_q, wait0_d;
  logic [3:0] wait1_q, wait1_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;
  logic       gnt0, gnt1;

  // Lock beats starvation, starvation beats base priority.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (active_q) begin
      if (owner_q && m1_lock && m1_req) begin
        gnt1 = 1'b1;
      end else if ((wait0_q >= MAX_WAIT_C) && m0_req) begin
        gnt0 = 1'b1;
      end else if ((wait1_q >= MAX_WAIT_C) && m1_req) begin
        gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
`ifdef RAM_ARB_RR_EN
        if (owner_q) gnt0 = 1'b1;
        else         gnt1 = 1'b1;
`else
        gnt1 = 1'b1;
`endif
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end
    end
  end

  always_comb begin
    m0_ready  = gnt0;
    m1_ready  = gnt1;
    ram_en    = gnt0 | gnt1;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt1) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end else if (gnt0) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end
    m0_rvalid = active_q && rd_pend_q && !rd_id_q;
    m1_rvalid = active_q && rd_pend_q && rd_id_q;
    m0_rdata  = (active_q && !rd_id_q) ? ram_rdata : '0;
    m1_rdata  = (active_q && rd_id_q) ? ram_rdata : '0;
  end

  always_comb begin
    active_d  = 1'b1;
    owner_d   = owner_q;
    wait0_d   = wait0_q;
    wait1_d   = wait1_q;
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    if (gnt0) owner_d = 1'b0;
    if (gnt1) owner_d = 1'b1;
    if (active_q) begin
      if (gnt0 || !m0_req)      wait0_d = 4'd0;
      else if (wait0_q != 4'hF) wait0_d = wait0_q + 4'd1;
      if (gnt1 || !m1_req)      wait1_d = 4'd0;
      else if (wait1_q != 4'hF) wait1_d = wait1_q + 4'd1;
    end
    // Read data comes back one cycle after the grant; remember whose it is.
    if (gnt0 && (m0_we == '0)) begin
      rd_pend_d = 1'b1;
      rd_id_d   = 1'b0;
    end else if (gnt1 && (m1_we == '0)) begin
      rd_pend_d = 1'b1;
      rd_id_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      active_q  <= 1'b0;
      owner_q   <= 1'b0;
      wait0_q   <= 4'd0;
      wait1_q   <= 4'd0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
    end else begin
      active_q  <= active_d;
      owner_q   <= owner_d;
      wait0_q   <= wait0_d;
      wait1_q   <= wait1_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb with a RAM model and a read-return scoreboard.
module tb_ram_port_arb;

  logic        clk = 1'b0;
  logic        rstb;
  logic        m0_req, m1_req, m1_lock;
  logic [3:0]  m0_we, m1_we;
  logic [13:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];

  ram_port_arb #(.XLEN(32), .RAM_ADDR_LEN(14), .MAX_WAIT(4)) dut (
    .clk(clk), .rstb(rstb),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_lock(m1_lock),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // 1-cycle read-first RAM
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      if (ram_we == 4'h0) ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  task automatic shadow_wr(input logic [13:0] a, input logic [3:0] we, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (we[b]) shadow[a[7:0]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Scoreboard: pop the read accepted last cycle, then push this cycle's accepted read.
  always @(negedge clk) begin
    exp_t e;
    if (!rstb) begin
      sb_q.delete();
      chk("rvalid_in_reset", {m1_rvalid, m0_rvalid}, 2'b00);
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.id) begin
          chk("m1_rvalid", m1_rvalid, 1'b1);
          chk("m1_rdata", m1_rdata, e.data);
          chk("m0_rvalid_idle", m0_rvalid, 1'b0);
        end else begin
          chk("m0_rvalid", m0_rvalid, 1'b1);
          chk("m0_rdata", m0_rdata, e.data);
          chk("m1_rvalid_idle", m1_rvalid, 1'b0);
        end
      end else begin
        chk("no_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      end
      chk("ready_onehot", m0_ready & m1_ready, 1'b0);
      if (m0_ready) begin
        if (m0_we == 4'h0) begin
          e.id = 1'b0; e.data = shadow[m0_addr[7:0]]; sb_q.push_back(e);
        end else shadow_wr(m0_addr, m0_we, m0_wdata);
      end
      if (m1_ready) begin
        if (m1_we == 4'h0) begin
          e.id = 1'b1; e.data = shadow[m1_addr[7:0]]; sb_q.push_back(e);
        end else shadow_wr(m1_addr, m1_we, m1_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0; m1_lock = 0;
    m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rdy"}, {m1_ready, m0_ready, m1_rvalid, m0_rvalid, ram_en}, 5'b0);
    chk({tag, "_ram"}, {ram_we, ram_addr, ram_wdata}, 50'b0);
    chk({tag, "_rdata"}, {m1_rdata, m0_rdata}, 64'b0);
  endtask

  task automatic do_reset();
    idle();
    rstb = 0;
    @(negedge clk); check_all_zero("rst");
    tick();
    rstb = 1;
    @(negedge clk); chk("rel_ready", {m1_ready, m0_ready}, 2'b00);
    tick();
  endtask

  task automatic single(input logic m, input logic [3:0] we, input logic [13:0] a, input logic [31:0] d);
    if (m) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    @(negedge clk);
    chk(m ? "single_m1_ready" : "single_m0_ready", m ? m1_ready : m0_ready, 1'b1);
    chk("single_ram_addr", ram_addr, a);
    tick();
    m0_req = 0; m1_req = 0;
  endtask

  initial begin
    logic exp_g1;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; shadow[i] = '0; end
    idle();
    rstb = 0;
    m0_req = 1; m0_addr = 14'h3;
    // reset held with a live request
    @(negedge clk); check_all_zero("rst_hold0");
    tick();
    @(negedge clk); check_all_zero("rst_hold1");
    tick();
    rstb = 1;
    @(negedge clk); check_all_zero("first_clk");
    tick();
    @(negedge clk);
    chk("second_clk_ready", m0_ready, 1'b1);
    chk("second_clk_addr", ram_addr, 14'h3);
    tick();
    m0_req = 0;

    // m0 write then read
    m0_req = 1; m0_we = 4'hF; m0_addr = 14'h10; m0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_ready", m0_ready, 1'b1);
    chk("wr_ram_en", ram_en, 1'b1);
    chk("wr_ram_we", ram_we, 4'hF);
    chk("wr_ram_addr", ram_addr, 14'h10);
    chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    tick();
    m0_we = 4'h0;
    @(negedge clk);
    chk("rd_ready", m0_ready, 1'b1);
    chk("rd_ram_we", ram_we, 4'h0);
    tick();
    m0_req = 0;
    @(negedge clk);
    chk("rd_rvalid", m0_rvalid, 1'b1);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", m1_rvalid, 1'b0);
    tick();

    // partial byte write and read-back
    single(1'b0, 4'b0011, 14'h10, 32'h12345678);
    single(1'b0, 4'b0000, 14'h10, 32'h0);
    single(1'b0, 4'hF, 14'h20, 32'h0BADF00D);
    single(1'b1, 4'hF, 14'h21, 32'hA5A51111);
    idle(); tick();

    // contention with both requesters reading
    do_reset();
    m0_req = 1; m0_addr = 14'h20; m1_req = 1; m1_addr = 14'h21;
    for (int i = 0; i < 10; i++) begin
`ifdef RAM_ARB_RR_EN
      exp_g1 = (i % 2 == 0);
`else
      exp_g1 = (i % 5 != 4);
`endif
      @(negedge clk);
      chk("cont_m1_ready", m1_ready, exp_g1);
      chk("cont_m0_ready", m0_ready, !exp_g1);
      tick();
    end
    idle(); tick();

    // locked m1 burst against a waiting m0
    do_reset();
    m0_req = 1; m0_addr = 14'h20;
    m1_req = 1; m1_lock = 1; m1_we = 4'hF;
    for (int k = 0; k < 10; k++) begin
      m1_addr = 14'h40 + 14'(k); m1_wdata = 32'h1000 + 32'(k);
      @(negedge clk);
      chk("lock_m1_ready", m1_ready, 1'b1);
      chk("lock_m0_ready", m0_ready, 1'b0);
      chk("lock_ram_addr", ram_addr, 14'h40 + 14'(k));
      tick();
    end
    m1_lock = 0; m1_addr = 14'h4A; m1_wdata = 32'h100A;
    @(negedge clk);
    chk("unlock_m0_ready", m0_ready, 1'b1);
    chk("unlock_m1_ready", m1_ready, 1'b0);
    tick();
    m0_req = 0;
    @(negedge clk);
    chk("after_unlock_m1", m1_ready, 1'b1);
    tick();
    idle();
    single(1'b0, 4'h0, 14'h45, 32'h0);
    idle(); tick();

    // reset while a read is in flight
    m1_req = 1; m1_we = 4'h0; m1_addr = 14'h21;
    @(negedge clk);
    chk("mid_rd_ready", m1_ready, 1'b1);
    tick();
    rstb = 0; m1_req = 0;
    @(negedge clk);
    chk("mid_rd_rvalid", m1_rvalid, 1'b0);
    tick();
    rstb = 1;
    @(negedge clk); chk("mid_rel_rvalid0", m1_rvalid, 1'b0);
    tick();
    @(negedge clk); chk("mid_rel_rvalid1", m1_rvalid, 1'b0);
    tick();
    single(1'b1, 4'h0, 14'h21, 32'h0);
    idle(); tick();
    tick();
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
